// File: rtl/debug_bus_arbiter_pkg.sv
// Shared definitions for the 8-bit debug register bus and its arbiter:
// command/response codes, FSM encoding, payload structs and a request helper.
package debug_bus_arbiter_pkg;

    localparam int unsigned CMD_W  = 3;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CMD_W-1:0] MCMD_IDLE = 3'b000;
    localparam logic [CMD_W-1:0] MCMD_WR   = 3'b001;
    localparam logic [CMD_W-1:0] MCMD_RD   = 3'b010;

    localparam logic [RESP_W-1:0] SRESP_NULL = 2'b00;
    localparam logic [RESP_W-1:0] SRESP_DVA  = 2'b01;
    localparam logic [RESP_W-1:0] SRESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_CMD       = 2'b01,
        ST_WAIT_RESP = 2'b10
    } state_t;

    // Master-to-target command payload
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_cmd_t;

    // Target-to-master return payload
    typedef struct packed {
        logic              accept;
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] data;
    } bus_rsp_t;

    // Only write and read codes count as requests; everything else is idle
    function automatic logic is_request(input logic [CMD_W-1:0] cmd);
        return (cmd == MCMD_WR) || (cmd == MCMD_RD);
    endfunction

endpackage

// File: rtl/debug_bus_arbiter_rr_pick.sv
// Two-way round-robin pick (combinational).
//   req  : request vector, bit i = master i requesting
//   last : index of the master granted most recently
//   gnt  : one-hot winner, 00 when nobody requests
module debug_bus_arbiter_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester always wins; on a tie the one not granted last wins
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/debug_bus_arbiter.sv
// Two-master round-robin arbiter for the debug register bus. One transaction
// is outstanding at a time; reads that get no target response within
// RESP_TIMEOUT wait cycles are completed with ERR.
//   clk, reset_n                 : clock, async active-low reset
//   m0_* / m1_* (MCmd/MAddr/MData in; SCmdAccept/SData/SResp out) : masters
//   s_*  (MCmd/MAddr/MData out; SCmdAccept/SData/SResp in)         : target
//   arb_grant                    : one-hot owner, 00 in IDLE
//   timeout_err                  : pulses in the cycle ERR is issued
module debug_bus_arbiter
    import debug_bus_arbiter_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CMD_W-1:0]  m0_MCmd,
    input  logic [ADDR_W-1:0] m0_MAddr,
    input  logic [DATA_W-1:0] m0_MData,
    output logic              m0_SCmdAccept,
    output logic [DATA_W-1:0] m0_SData,
    output logic [RESP_W-1:0] m0_SResp,
    input  logic [CMD_W-1:0]  m1_MCmd,
    input  logic [ADDR_W-1:0] m1_MAddr,
    input  logic [DATA_W-1:0] m1_MData,
    output logic              m1_SCmdAccept,
    output logic [DATA_W-1:0] m1_SData,
    output logic [RESP_W-1:0] m1_SResp,
    output logic [CMD_W-1:0]  s_MCmd,
    output logic [ADDR_W-1:0] s_MAddr,
    output logic [DATA_W-1:0] s_MData,
    input  logic              s_SCmdAccept,
    input  logic [DATA_W-1:0] s_SData,
    input  logic [RESP_W-1:0] s_SResp,
    output logic [1:0]        arb_grant,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RESP_TIMEOUT);

    state_t           state, next_state;
    logic             r_last;
    logic [1:0]       r_grant;
    logic [CNT_W-1:0] r_cnt;

    logic [1:0] req;
    logic [1:0] pick_gnt;
    logic       grant_load;
    logic       cnt_clr;
    logic       cnt_inc;

    bus_cmd_t m0_cmd, m1_cmd, sel_cmd, s_cmd;
    bus_rsp_t rsp, m0_rsp, m1_rsp;

    assign m0_cmd  = '{cmd: m0_MCmd, addr: m0_MAddr, data: m0_MData};
    assign m1_cmd  = '{cmd: m1_MCmd, addr: m1_MAddr, data: m1_MData};
    assign sel_cmd = r_grant[1] ? m1_cmd : m0_cmd;
    assign req     = {is_request(m1_MCmd), is_request(m0_MCmd)};

    debug_bus_arbiter_rr_pick u_pick (
        .req  (req),
        .last (r_last),
        .gnt  (pick_gnt)
    );

    // State, owner, round-robin history and response-wait counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
            r_cnt   <= '0;
        end else begin
            state <= next_state;
            if (grant_load) begin
                r_grant <= pick_gnt;
                r_last  <= pick_gnt[1];
            end
            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (cnt_inc && (r_cnt < CNT_LIMIT)) begin
                r_cnt <= CNT_W'(r_cnt + 1'b1);
            end
        end
    end

    // Next-state and bus muxing; target traffic is only looked at in the
    // state that expects it, so stray accepts/responses are dropped.
    always_comb begin
        next_state  = state;
        grant_load  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        s_cmd       = '0;
        rsp         = '0;
        timeout_err = 1'b0;

        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_load = 1'b1;
                    next_state = ST_CMD;
                end
            end
            ST_CMD: begin
                s_cmd      = sel_cmd;
                rsp.accept = s_SCmdAccept;
                if (s_SCmdAccept) begin
                    if (sel_cmd.cmd == MCMD_RD) begin
                        cnt_clr    = 1'b1;
                        next_state = ST_WAIT_RESP;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_WAIT_RESP: begin
                // A real response beats a timeout landing in the same cycle
                if (s_SResp != SRESP_NULL) begin
                    rsp.resp   = s_SResp;
                    rsp.data   = s_SData;
                    next_state = ST_IDLE;
                end else if (r_cnt == CNT_LIMIT) begin
                    rsp.resp    = SRESP_ERR;
                    timeout_err = 1'b1;
                    next_state  = ST_IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Only the owner sees the return path; r_grant is stale in IDLE but rsp is zero there
    assign m0_rsp = r_grant[0] ? rsp : '0;
    assign m1_rsp = r_grant[1] ? rsp : '0;

    assign m0_SCmdAccept = m0_rsp.accept;
    assign m0_SResp      = m0_rsp.resp;
    assign m0_SData      = m0_rsp.data;
    assign m1_SCmdAccept = m1_rsp.accept;
    assign m1_SResp      = m1_rsp.resp;
    assign m1_SData      = m1_rsp.data;

    assign s_MCmd  = s_cmd.cmd;
    assign s_MAddr = s_cmd.addr;
    assign s_MData = s_cmd.data;

    assign arb_grant = (state == ST_IDLE) ? 2'b00 : r_grant;

endmodule
